// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter slice.
//   WB_ADDR_WIDTH / WB_DATA_WIDTH / WB_CNT_WIDTH : default register index, data and
//                                                  pending-counter widths
//   src_e    : result source identifier (EXU / LSU)
//   wb_req_t : one result payload as presented by a producing unit
package wb_pkg;

   localparam int unsigned WB_ADDR_WIDTH = 5;
   localparam int unsigned WB_DATA_WIDTH = 32;
   localparam int unsigned WB_CNT_WIDTH  = 2;

   typedef enum logic {
      SRC_EXU = 1'b0,
      SRC_LSU = 1'b1
   } src_e;

   typedef struct packed {
      logic                     wen;
      logic [WB_ADDR_WIDTH-1:0] rd;
      logic [WB_DATA_WIDTH-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard.
//   clk, rst      : clock, synchronous active-high reset
//   issue_valid   : decode issues an instruction writing issue_rd
//   issue_rd      : destination of the issuing instruction
//   retire_valid  : a write to retire_rd is leaving writeback this cycle
//   retire_rd     : destination of the retiring write
//   issue_ready   : low when issue_rd's counter is saturated
//   busy_vec      : bit i set when register i has a pending write
module wb_scoreboard
   import wb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
   parameter int unsigned CNT_WIDTH  = WB_CNT_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       issue_valid,
   input  logic [ADDR_WIDTH-1:0]      issue_rd,
   input  logic                       retire_valid,
   input  logic [ADDR_WIDTH-1:0]      retire_rd,
   output logic                       issue_ready,
   output logic [2**ADDR_WIDTH-1:0]   busy_vec
);

   localparam int unsigned NREGS = 2**ADDR_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [CNT_WIDTH-1:0] cnt [NREGS];
   logic                 inc;
   logic [NREGS-1:0]     inc_vec;
   logic [NREGS-1:0]     dec_vec;

   // x0 is never tracked, so it is always ready
   assign issue_ready = (issue_rd == '0) || (cnt[issue_rd] != CNT_MAX);
   assign inc         = issue_valid && issue_ready && (issue_rd != '0);

   // One-hot increment/decrement selects and busy decode; entry 0 stays idle
   always_comb begin
      inc_vec  = '0;
      dec_vec  = '0;
      busy_vec = '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
         inc_vec[i]  = inc && (issue_rd == ADDR_WIDTH'(i));
         dec_vec[i]  = retire_valid && (retire_rd == ADDR_WIDTH'(i));
         busy_vec[i] = (cnt[i] != '0);
      end
   end

   // Counter update; a simultaneous issue and retire to one register cancel out
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (inc_vec[i] && !dec_vec[i] && (cnt[i] != CNT_MAX))
               cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0))
               cnt[i] <= cnt[i] - CNT_WIDTH'(1);
         end
      end
   end

   // A retiring write must always have a matching pending issue
   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      (retire_valid && (retire_rd != '0)) |-> (cnt[retire_rd] != '0));

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: round-robin arbitration of EXU/LSU results into one registered
// register-file write per cycle, plus the RAW pending-write scoreboard.
//   clk, rst                     : clock, synchronous active-high reset
//   exu_* / lsu_*                : result valid/ready handshake with wen, rd, data
//   issue_valid, issue_rd        : decode issue of an instruction writing issue_rd
//   issue_ready                  : low when issue_rd has saturated pending writes
//   busy_vec                     : per-register pending-write flags
//   rf_wen, rf_waddr, rf_wdata   : register file write port (registered)
//   wb_done                      : one-cycle pulse per retired result
//   byp_valid, byp_rd, byp_data  : forwarding view of the registered write,
//                                  present only with WB_ARBITER_BYPASS_EN defined
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
   parameter int unsigned CNT_WIDTH  = WB_CNT_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      exu_valid,
   output logic                      exu_ready,
   input  logic                      exu_wen,
   input  logic [ADDR_WIDTH-1:0]     exu_rd,
   input  logic [DATA_WIDTH-1:0]     exu_data,
   input  logic                      lsu_valid,
   output logic                      lsu_ready,
   input  logic                      lsu_wen,
   input  logic [ADDR_WIDTH-1:0]     lsu_rd,
   input  logic [DATA_WIDTH-1:0]     lsu_data,
   input  logic                      issue_valid,
   input  logic [ADDR_WIDTH-1:0]     issue_rd,
   output logic                      issue_ready,
   output logic [2**ADDR_WIDTH-1:0]  busy_vec,
   output logic                      rf_wen,
   output logic [ADDR_WIDTH-1:0]     rf_waddr,
   output logic [DATA_WIDTH-1:0]     rf_wdata,
`ifdef WB_ARBITER_BYPASS_EN
   output logic                      byp_valid,
   output logic [ADDR_WIDTH-1:0]     byp_rd,
   output logic [DATA_WIDTH-1:0]     byp_data,
`endif
   output logic                      wb_done
);

   src_e                  last_grant;
   logic                  fire;
   logic                  sel_wen;
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;

   // Round-robin grant: on a tie the source not granted last wins
   always_comb begin
      exu_ready = 1'b0;
      lsu_ready = 1'b0;
      if (exu_valid && lsu_valid) begin
         if (last_grant == SRC_EXU) lsu_ready = 1'b1;
         else                       exu_ready = 1'b1;
      end else begin
         exu_ready = exu_valid;
         lsu_ready = lsu_valid;
      end
   end

   assign fire     = exu_ready || lsu_ready;
   assign sel_wen  = lsu_ready ? lsu_wen  : exu_wen;
   assign sel_rd   = lsu_ready ? lsu_rd   : exu_rd;
   assign sel_data = lsu_ready ? lsu_data : exu_data;

   // Output register; results to x0 or with wen=0 retire without writing
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= SRC_EXU;
         rf_wen     <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         wb_done    <= 1'b0;
      end else begin
         wb_done <= fire;
         rf_wen  <= fire && sel_wen && (sel_rd != '0);
         if (fire) begin
            rf_waddr   <= sel_rd;
            rf_wdata   <= sel_data;
            last_grant <= lsu_ready ? SRC_LSU : SRC_EXU;
         end
      end
   end

   wb_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .retire_valid (rf_wen),
      .retire_rd    (rf_waddr),
      .issue_ready  (issue_ready),
      .busy_vec     (busy_vec)
   );

`ifdef WB_ARBITER_BYPASS_EN
   // Lets decode forward the value before the register file write lands
   assign byp_valid = rf_wen && (rf_waddr != '0);
   assign byp_rd    = rf_waddr;
   assign byp_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

   localparam int CNT_MAX = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        exu_valid, exu_ready, exu_wen;
   logic [4:0]  exu_rd;
   logic [31:0] exu_data;
   logic        lsu_valid, lsu_ready, lsu_wen;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        issue_valid, issue_ready;
   logic [4:0]  issue_rd;
   logic [31:0] busy_vec;
   logic        rf_wen, wb_done;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   wb_arbiter dut (
      .clk(clk), .rst(rst),
      .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
      .exu_rd(exu_rd), .exu_data(exu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
      .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .busy_vec(busy_vec),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .wb_done(wb_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: pending counts, in-flight reservations, expected write port
   int          m_cnt [32];
   int          resv  [32];
   int          m_last;
   logic        m_wen, m_done;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;

   typedef struct {
      logic ev; logic ew; logic [4:0] erd; logic [31:0] ed;
      logic lv; logic lw; logic [4:0] lrd; logic [31:0] ld;
      logic iv; logic [4:0] ird;
      logic x_er; logic x_lr; logic x_ir;
      logic x_wen; logic [4:0] x_wa; logic [31:0] x_wd; logic x_done; logic [31:0] x_busy;
   } vec_t;
   vec_t tbl [9];

   task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin m_cnt[i] = 0; resv[i] = 0; end
      m_last = 0; m_wen = 1'b0; m_done = 1'b0; m_waddr = '0; m_wdata = '0;
   endtask

   function automatic int model_grant();
      if (exu_valid && lsu_valid) return (m_last == 0) ? 1 : 0;
      if (exu_valid) return 0;
      if (lsu_valid) return 1;
      return -1;
   endfunction

   function automatic logic model_issue_ready();
      return (issue_rd == 5'd0) || (m_cnt[issue_rd] != CNT_MAX);
   endfunction

   function automatic logic [31:0] model_busy();
      logic [31:0] b = '0;
      for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
      return b;
   endfunction

   task automatic drive(input logic ev, input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                        input logic lv, input logic lw, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic iv, input logic [4:0] ird);
      exu_valid = ev; exu_wen = ew; exu_rd = erd; exu_data = ed;
      lsu_valid = lv; lsu_wen = lw; lsu_rd = lrd; lsu_data = ld;
      issue_valid = iv; issue_rd = ird;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // One clock: check handshake outputs, advance the model, check registered outputs
   task automatic step();
      int   g;
      logic ir;
      logic s_wen;
      logic [4:0] s_rd;
      #1;
      g  = model_grant();
      ir = model_issue_ready();
      check1("exu_ready", 64'(exu_ready), 64'(g == 0));
      check1("lsu_ready", 64'(lsu_ready), 64'(g == 1));
      check1("issue_ready", 64'(issue_ready), 64'(ir));
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (m_wen && m_waddr != 0) begin
            if (m_cnt[m_waddr] > 0) m_cnt[m_waddr]--;
            if (resv[m_waddr] > 0)  resv[m_waddr]--;
         end
         if (issue_valid && ir && issue_rd != 0) m_cnt[issue_rd]++;
         if (g >= 0) begin
            s_wen   = (g == 1) ? lsu_wen : exu_wen;
            s_rd    = (g == 1) ? lsu_rd  : exu_rd;
            m_wdata = (g == 1) ? lsu_data : exu_data;
            m_waddr = s_rd;
            m_wen   = s_wen && (s_rd != 0);
            m_done  = 1'b1;
            m_last  = g;
            if (m_wen) resv[s_rd]++;
         end else begin
            m_wen  = 1'b0;
            m_done = 1'b0;
         end
      end
      #1;
      check1("rf_wen", 64'(rf_wen), 64'(m_wen));
      check1("wb_done", 64'(wb_done), 64'(m_done));
      if (m_wen) begin
         check1("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
         check1("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
      end
      check1("busy_vec", 64'(busy_vec), 64'(model_busy()));
   endtask

   // Random producer: writes only target registers with an unreserved pending issue
   task automatic rand_src(output logic v, output logic w, output logic [4:0] rd, output logic [31:0] d);
      int cand[$];
      v = ($urandom_range(0, 2) != 0);
      d = $urandom();
      for (int i = 1; i < 32; i++) if (m_cnt[i] - resv[i] > 0) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
         w  = 1'b1;
         rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if ($urandom_range(0, 1) == 1) begin
         w = 1'b1; rd = 5'd0;
      end else begin
         w = 1'b0; rd = 5'($urandom_range(0, 31));
      end
   endtask

   initial begin
      //          ev ew erd  ed            lv lw lrd  ld         iv ird  er lr ir  wen wa  wd            done busy
      tbl[0] = '{0, 0, 0, 32'h0,         0, 0, 0, 32'h0,     1, 5,   0, 0, 1,  0, 0, 32'h0,        0, 32'h20};
      tbl[1] = '{1, 1, 5, 32'hDEADBEEF,  0, 0, 0, 32'h0,     1, 1,   1, 0, 1,  1, 5, 32'hDEADBEEF, 1, 32'h22};
      tbl[2] = '{0, 0, 0, 32'h0,         0, 0, 0, 32'h0,     1, 2,   0, 0, 1,  0, 0, 32'h0,        0, 32'h06};
      tbl[3] = '{1, 1, 1, 32'hA1,        1, 1, 2, 32'hB2,    1, 1,   0, 1, 1,  1, 2, 32'hB2,       1, 32'h06};
      tbl[4] = '{1, 1, 1, 32'hA1,        1, 1, 2, 32'hB2,    1, 2,   1, 0, 1,  1, 1, 32'hA1,       1, 32'h06};
      tbl[5] = '{1, 1, 1, 32'hA1,        1, 1, 2, 32'hB2,    0, 0,   0, 1, 1,  1, 2, 32'hB2,       1, 32'h06};
      tbl[6] = '{1, 1, 1, 32'hA1,        1, 1, 2, 32'hB2,    0, 0,   1, 0, 1,  1, 1, 32'hA1,       1, 32'h02};
      tbl[7] = '{0, 0, 0, 32'h0,         1, 1, 0, 32'h1234,  1, 3,   0, 1, 1,  0, 0, 32'h0,        1, 32'h08};
      tbl[8] = '{0, 0, 0, 32'h0,         0, 0, 0, 32'h0,     0, 0,   0, 0, 1,  0, 0, 32'h0,        0, 32'h08};

      model_reset();
      idle();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;

      // Idle after reset
      for (int c = 0; c < 10; c++) begin
         issue_rd = 5'(c + 1);
         step();
         check1("idle_rf_wen", 64'(rf_wen), 64'd0);
         check1("idle_wb_done", 64'(wb_done), 64'd0);
         check1("idle_busy_vec", 64'(busy_vec), 64'd0);
         check1("idle_issue_ready", 64'(issue_ready), 64'd1);
      end
      issue_rd = 5'd0;

      // Directed vector table
      for (int r = 0; r < 9; r++) begin
         drive(tbl[r].ev, tbl[r].ew, tbl[r].erd, tbl[r].ed, tbl[r].lv, tbl[r].lw, tbl[r].lrd,
               tbl[r].ld, tbl[r].iv, tbl[r].ird);
         #1;
         check1($sformatf("tbl%0d_exu_ready", r), 64'(exu_ready), 64'(tbl[r].x_er));
         check1($sformatf("tbl%0d_lsu_ready", r), 64'(lsu_ready), 64'(tbl[r].x_lr));
         check1($sformatf("tbl%0d_issue_ready", r), 64'(issue_ready), 64'(tbl[r].x_ir));
         step();
         check1($sformatf("tbl%0d_rf_wen", r), 64'(rf_wen), 64'(tbl[r].x_wen));
         check1($sformatf("tbl%0d_wb_done", r), 64'(wb_done), 64'(tbl[r].x_done));
         if (tbl[r].x_wen) begin
            check1($sformatf("tbl%0d_rf_waddr", r), 64'(rf_waddr), 64'(tbl[r].x_wa));
            check1($sformatf("tbl%0d_rf_wdata", r), 64'(rf_wdata), 64'(tbl[r].x_wd));
         end
         check1($sformatf("tbl%0d_busy_vec", r), 64'(busy_vec), 64'(tbl[r].x_busy));
      end

      // Scoreboard saturation and same-cycle issue/retire on x7
      for (int k = 0; k < 3; k++) begin drive(0,0,0,0, 0,0,0,0, 1,7); step(); end
      drive(0,0,0,0, 0,0,0,0, 1,7);
      #1;
      check1("sat_issue_ready_x7", 64'(issue_ready), 64'd0);
      check1("sat_busy_x7", 64'(busy_vec[7]), 64'd1);
      step();
      drive(1,1,7,32'h77, 0,0,0,0, 0,0); step();
      idle(); step();
      drive(1,1,7,32'h78, 0,0,0,0, 0,0); step();
      drive(0,0,0,0, 0,0,0,0, 1,7); step();
      drive(0,0,0,0, 0,0,0,0, 1,7);
      #1;
      check1("same_cycle_issue_ready_x7", 64'(issue_ready), 64'd1);
      step();
      drive(0,0,0,0, 0,0,0,0, 1,7);
      #1;
      check1("resat_issue_ready_x7", 64'(issue_ready), 64'd0);
      step();
      for (int k = 0; k < 3; k++) begin drive(0,0,0,0, 1,1,7,32'h700 + k, 0,0); step(); end
      idle(); step(); step();
      check1("drained_busy_x7", 64'(busy_vec[7]), 64'd0);

      // Reset asserted on the cycle a write is accepted
      drive(0,0,0,0, 0,0,0,0, 1,9);  step();
      drive(0,0,0,0, 0,0,0,0, 1,10); step();
      drive(1,1,9,32'h99, 0,0,0,0, 0,0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check1("rst_rf_wen", 64'(rf_wen), 64'd0);
      check1("rst_busy_vec", 64'(busy_vec), 64'd0);
      idle(); step();
      check1("post_rst_rf_wen", 64'(rf_wen), 64'd0);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         logic v, w; logic [4:0] rd; logic [31:0] d;
         rand_src(v, w, rd, d);
         exu_valid = v; exu_wen = w; exu_rd = rd; exu_data = d;
         rand_src(v, w, rd, d);
         lsu_valid = v; lsu_wen = w; lsu_rd = rd; lsu_data = d;
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_rd    = 5'($urandom_range(0, 31));
         rst         = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0;
      idle(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
